// File: rtl/hamming_tx_serializer_if.sv
// Codeword handshake between the Hamming encoder (master) and the serializer (slave).
interface hamming_tx_serializer_if;
    logic [11:0] hc_in;
    logic        hc_valid;
    logic        hc_ready;

    modport master (
        output hc_in,
        output hc_valid,
        input  hc_ready
    );

    modport slave (
        input  hc_in,
        input  hc_valid,
        output hc_ready
    );
endinterface

// File: rtl/hamming_tx_serializer.sv
// Shifts one 12-bit Hamming codeword per handshake onto a UART-style line:
// start bit, 12 data bits LSB first, stop bit, each held CLKS_PER_BIT clocks.
module hamming_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming_tx_serializer_if.slave  hc,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;
    logic [11:0]     shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            bit_end;

    assign bit_end = (baud_q == BaudLast);

    // tx_d is the line value for the state being entered, so tx stays a pure flop output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (hc.hc_valid) begin
                    shift_d = hc.hc_in;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[11:1]};
                    if (bit_q == 4'd11) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx          = tx_q;
    assign done        = done_q;
    assign busy        = (state_q != StIdle);
    assign hc.hc_ready = (state_q == StIdle);

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed bench for hamming_tx_serializer: one instance at C=4, one at C=2.
module tb_hamming_tx_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_tx_serializer_if if4 ();
    hamming_tx_serializer_if if2 ();

    logic tx4, busy4, done4;
    logic tx2, busy2, done2;

    hamming_tx_serializer #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .hc    (if4),
        .tx    (tx4),
        .busy  (busy4),
        .done  (done4)
    );

    hamming_tx_serializer #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .hc    (if2),
        .tx    (tx2),
        .busy  (busy2),
        .done  (done2)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line level j clocks after the acceptance edge.
    function automatic logic exp_tx(input logic [11:0] w, input int j, input int c);
        int s = j / c;
        if (s == 0) return 1'b0;
        else if (s <= 12) return w[s-1];
        else return 1'b1;
    endfunction

    function automatic logic get_tx(input bit u2);
        return u2 ? tx2 : tx4;
    endfunction
    function automatic logic get_busy(input bit u2);
        return u2 ? busy2 : busy4;
    endfunction
    function automatic logic get_done(input bit u2);
        return u2 ? done2 : done4;
    endfunction
    function automatic logic get_ready(input bit u2);
        return u2 ? if2.hc_ready : if4.hc_ready;
    endfunction

    task automatic drive(input bit u2, input logic [11:0] word, input logic valid);
        if (u2) begin
            if2.hc_in    = word;
            if2.hc_valid = valid;
        end else begin
            if4.hc_in    = word;
            if4.hc_valid = valid;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the acceptance edge.
    task automatic accept(input bit u2, input logic [11:0] word, input bit hold, input string tag);
        drive(u2, word, 1'b1);
        check_val({tag, ".ready_before"}, 32'(get_ready(u2)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) drive(u2, word, 1'b0);
    endtask

    // Watches one frame from j=0 to j=14C (done cycle); returns at that negedge.
    task automatic observe(input bit u2, input logic [11:0] word, input string tag,
                           input bit tamper);
        int c = u2 ? 2 : 4;
        int bad_line = 0;
        int early_done = 0;
        int bad_hs = 0;
        logic [11:0] rec = '0;
        for (int j = 0; j <= 14 * c; j++) begin
            if (j > 0) @(negedge clk);
            if (get_tx(u2) !== exp_tx(word, j, c)) bad_line++;
            if (j < 14 * c) begin
                if (get_done(u2)) early_done++;
                if (get_ready(u2) || !get_busy(u2)) bad_hs++;
            end
            if ((j % c) == (c / 2) && (j / c) >= 1 && (j / c) <= 12) rec[j/c-1] = get_tx(u2);
            if (tamper) begin
                if (j < 14 * c - 1) drive(u2, 12'($urandom), 1'($urandom));
                else drive(u2, word, 1'b0);
            end
        end
        check_val({tag, ".line_errs"}, 32'(bad_line), 32'd0);
        check_val({tag, ".word"}, 32'(rec), 32'(word));
        check_val({tag, ".early_done"}, 32'(early_done), 32'd0);
        check_val({tag, ".busy_ready"}, 32'(bad_hs), 32'd0);
        check_val({tag, ".done_end"}, 32'(get_done(u2)), 32'd1);
        check_val({tag, ".ready_end"}, 32'(get_ready(u2)), 32'd1);
        check_val({tag, ".busy_end"}, 32'(get_busy(u2)), 32'd0);
    endtask

    task automatic check_idle(input bit u2, input string tag);
        check_val({tag, ".tx"}, 32'(get_tx(u2)), 32'd1);
        check_val({tag, ".ready"}, 32'(get_ready(u2)), 32'd1);
        check_val({tag, ".busy"}, 32'(get_busy(u2)), 32'd0);
        check_val({tag, ".done"}, 32'(get_done(u2)), 32'd0);
    endtask

    initial begin
        int stray;
        drive(1'b0, 12'h000, 1'b0);
        drive(1'b1, 12'h000, 1'b0);

        // Reset state and persistence after release
        repeat (2) @(negedge clk);
        check_idle(1'b0, "rst4");
        check_idle(1'b1, "rst2");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(1'b0, "rel4");
        check_idle(1'b1, "rel2");

        // Single frame 12'hA5C at C=4
        accept(1'b0, 12'hA5C, 1'b0, "a5c");
        observe(1'b0, 12'hA5C, "a5c", 1'b0);
        @(negedge clk);
        check_val("a5c.done_drop", 32'(done4), 32'd0);

        // Back-to-back with hc_valid held; hc_in changes right after first acceptance
        accept(1'b0, 12'h001, 1'b1, "b2b1");
        drive(1'b0, 12'hFFF, 1'b1);
        observe(1'b0, 12'h001, "b2b1", 1'b0);
        @(negedge clk);
        drive(1'b0, 12'hFFF, 1'b0);
        observe(1'b0, 12'hFFF, "b2b2", 1'b0);
        @(negedge clk);
        check_val("b2b2.done_drop", 32'(done4), 32'd0);

        // Inputs toggled while busy are ignored
        accept(1'b0, 12'h3C3, 1'b0, "ign");
        observe(1'b0, 12'h3C3, "ign", 1'b1);
        @(negedge clk);
        check_val("ign.no_extra", 32'(busy4), 32'd0);
        @(negedge clk);
        check_val("ign.no_extra2", 32'(busy4), 32'd0);

        // Reset mid-frame at clock 20 (line is low there for 12'hF0F)
        accept(1'b0, 12'hF0F, 1'b0, "abort");
        repeat (20) @(negedge clk);
        check_val("abort.tx_before", 32'(tx4), 32'd0);
        rst_n = 1'b0;
        #1;
        check_idle(1'b0, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done4 || !tx4 || busy4) stray++;
        end
        check_val("abort.quiet", 32'(stray), 32'd0);
        accept(1'b0, 12'h5A5, 1'b0, "post");
        observe(1'b0, 12'h5A5, "post", 1'b0);

        // Minimum divider C=2
        @(negedge clk);
        accept(1'b1, 12'h800, 1'b0, "c2");
        observe(1'b1, 12'h800, "c2", 1'b0);
        @(negedge clk);
        check_val("c2.done_drop", 32'(done2), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_tx_serializer.md
# hamming_tx_serializer

Transmit-side serializer that sits directly downstream of the 12/8 Hamming encoder. It accepts one 12-bit codeword per valid/ready handshake and shifts it onto a single UART-style line: start bit, 12 codeword bits LSB first, then a stop bit, each bit held for a programmable number of clocks. It gives the codec a serial physical link without changing the codeword contents.

## Interface
- CLKS_PER_BIT, default 16: clocks per serial bit; legal range 2..65535.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- hc_in  in  12  codeword from the Hamming encoder, sampled on acceptance only.
- hc_valid  in  1  hc_in holds a codeword to send.
- hc_ready  out  1  block can accept a codeword this cycle.
- tx  out  1  serial line, registered, idles high.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- Reset (rst_n=0, takes effect immediately):
  - State is IDLE.
  - Outputs: tx=1, hc_ready=1, busy=0, done=0.
  - Counters and the shift register are cleared.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - hc_ready=1, busy=0, tx=1.
  - On a clock edge with hc_valid=1, the block loads hc_in into a 12-bit shift register, clears the baud counter, and moves to START.
- START:
  - tx=0 for CLKS_PER_BIT clocks, then moves to DATA with the bit index at 0.
- DATA:
  - tx = shift register bit 0, so bits go out LSB first.
  - Each bit is held for CLKS_PER_BIT clocks.
  - At the end of each bit the register shifts right and the bit index increments.
  - After bit index 11 completes, the block moves to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT clocks.
  - On completion: return to IDLE and pulse done=1 for exactly one clock.
- hc_ready=1 only in IDLE; busy=1 in START, DATA and STOP.
- hc_valid while busy is ignored. The source must hold hc_valid and the codeword until the handshake completes.
- Changes on hc_in after acceptance do not affect the frame in flight.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit index is 4 bits and counts 0..11.
- No parity or framing logic is added; error protection comes from the Hamming code.

## Timing
- Let E0 be the clock edge at which hc_valid=1 and hc_ready=1. Let C = CLKS_PER_BIT.
- After E0: tx=0, busy=1, hc_ready=0.
- Codeword bit i appears on tx after edge E0+(i+1)*C and is held until E0+(i+2)*C, for i = 0..11.
- Stop bit: tx=1 from E0+13C to E0+14C.
- After E0+14C:
  - State is IDLE, busy=0, hc_ready=1, done=1.
  - done drops after the next edge.
- Frame length on the line: 14*C clocks.
- Back-to-back frames:
  - If hc_valid is held high, the next acceptance happens at E0+14C+1.
  - This leaves exactly one idle-high clock between a stop bit and the next start bit.
  - Minimum frame period is 14*C+1 clocks.
- All outputs are registered; there is no combinational path from any input to tx.
- Reset mid-frame aborts the frame: tx=1 and hc_ready=1 immediately, with no done pulse. The first frame after reset release starts cleanly.

## Test plan
- Reset: assert rst_n=0 mid-operation -> tx=1, hc_ready=1, busy=0, done=0 within the same cycle, and these values persist after release while hc_valid=0.
- Single frame, C=4, hc_in=12'hA5C:
  - tx=0 for 4 clocks, then bits 0,0,1,1,1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks.
  - done pulses once at clock 56 after acceptance.
- Back-to-back, C=4: hc_valid held high with 12'h001 then 12'hFFF -> two correct frames separated by exactly 1 idle-high clock; second acceptance at clock 57.
- Inputs ignored while busy, C=4: toggle hc_in and hc_valid during a frame of 12'h3C3 -> the line carries 12'h3C3 unchanged and no extra acceptance occurs.
- Reset mid-frame, C=4: assert rst_n at clock 20 of a frame -> tx=1 at once and no done pulse; after release, a new frame with 12'h5A5 is sent correctly.
- Minimum divider, C=2, hc_in=12'h800 -> frame length 28 clocks, only bit 11 high, and the baud counter wraps correctly.
